video_pattern_gen: RTL and testbench

//  Parametrised composite-video test-pattern generator for the 263-line non-interlaced NTSC system.

---
 rtl/video_pattern_gen_pkg.sv | 43 ++++
 rtl/video_pattern_gen_if.sv | 31 +++
 rtl/video_pattern_gen_chroma_lut.sv | 34 +++
 rtl/video_pattern_gen.sv | 130 +++++++++++++
 tb/tb_video_pattern_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/video_pattern_gen_pkg.sv
// Shared types and helpers for the composite-video test-pattern generator.
// Mode codes, the chroma subcarrier table entry function and the DAC-code clamp.
package video_pattern_gen_pkg;

    typedef enum logic [1:0] {
        VSQ_MODE_RAMP = 2'd0,
        VSQ_MODE_BARS = 2'd1,
        VSQ_MODE_FLAT = 2'd2,
        VSQ_MODE_GRID = 2'd3
    } vsq_mode_e;

    // The 8-phase table is fixed by hand; wider phase words use a Bhaskara
    // sine approximation so the table can be built at elaboration time.
    function automatic logic signed [3:0] chroma_lut_entry(input int p, input int cph_w);
        int m, u, a, b, num, den, mag;
        if (cph_w == 3) begin
            case (p)
                0, 3:    return 4'sd3;
                1, 2:    return 4'sd6;
                4, 7:    return -4'sd3;
                default: return -4'sd6;
            endcase
        end
        m   = 1 << cph_w;
        u   = 2 * p + 1;
        a   = (u < m) ? u : u - m;
        b   = m - a;
        num = 96 * a * b;
        den = 5 * m * m - 4 * a * b;
        mag = (2 * num + den) / (2 * den);
        return 4'((u < m) ? mag : -mag);
    endfunction

    function automatic int clamp_code(input int v, input int max_code);
        if (v < 0)
            return 0;
        else if (v > max_code)
            return max_code;
        else
            return v;
    endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Timing, configuration and DAC-sample bundle between the timing generator
// side (master) and the pattern generator (slave).
interface video_pattern_gen_if #(
    parameter int C_VIDEO_W = 5,
    parameter int C_CPH_W   = 3
);
    logic                 ck_ee;
    logic [9:0]           hctr;
    logic [8:0]           vctr;
    logic [7:0]           fctr;
    logic                 xblk;
    logic                 xsync;
    logic                 burst;
    logic [C_CPH_W-1:0]   cph;
    logic [1:0]           mode;
    logic [C_VIDEO_W-1:0] level;
    logic [2:0]           gain;
    logic [C_VIDEO_W-1:0] video;
    logic [1:0]           mode_act;
    logic                 xsync_dly;

    modport master (
        output ck_ee, hctr, vctr, fctr, xblk, xsync, burst, cph, mode, level, gain,
        input  video, mode_act, xsync_dly
    );

    modport slave (
        input  ck_ee, hctr, vctr, fctr, xblk, xsync, burst, cph, mode, level, gain,
        output video, mode_act, xsync_dly
    );
endinterface

// File: rtl/video_pattern_gen_chroma_lut.sv
// Second pipeline stage: subcarrier phase to signed chroma, scaled by gain
// (gain 4 = unity) with a floor-rounding arithmetic shift.
module video_pattern_gen_chroma_lut
    import video_pattern_gen_pkg::*;
#(
    parameter int C_CPH_W = 3,
    parameter int OUT_W   = 7
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    en,
    input  logic [C_CPH_W-1:0]      phase,
    input  logic [2:0]              gain,
    output logic signed [OUT_W-1:0] chroma
);
    localparam int N_PH = 2 ** C_CPH_W;

    logic signed [3:0] lut [N_PH];
    logic signed [7:0] prod;

    for (genvar p = 0; p < N_PH; p++) begin : g_lut
        localparam logic signed [3:0] ENTRY = chroma_lut_entry(p, C_CPH_W);
        assign lut[p] = ENTRY;
    end

    assign prod = 8'(lut[phase]) * 8'($signed({1'b0, gain}));

    always_ff @(posedge clk_sys) begin
        if (rst)
            chroma <= '0;
        else if (en)
            chroma <= OUT_W'(prod >>> 2);
    end
endmodule

// File: rtl/video_pattern_gen.sv
// Composite-video test-pattern generator: three enabled stages from timing
// inputs to DAC code, with the mode latched only at the first pixel of a frame.
module video_pattern_gen
    import video_pattern_gen_pkg::*;
#(
    parameter int C_VIDEO_W = 5,
    parameter int C_PEDE    = 12,
    parameter int C_CPH_W   = 3,
    parameter int C_BAR_Y   = 8,
    parameter int C_RAMP_W  = 3
) (
    input logic clk_sys,
    input logic rst,
    video_pattern_gen_if.slave bus
);
    localparam int SW       = C_VIDEO_W + 2;
    localparam int MAX_CODE = 2 ** C_VIDEO_W - 1;
    localparam logic signed [SW-1:0] PEDE_S = SW'(C_PEDE);

    vsq_mode_e            mode_act;
    logic                 s1_xsync, s1_xblk, s1_burst;
    logic signed [SW-1:0] s1_luma;
    logic [C_CPH_W-1:0]   s1_phase;
    logic [2:0]           s1_gain;
    logic                 s2_xsync, s2_xblk, s2_burst;
    logic signed [SW-1:0] s2_luma;
    logic signed [SW-1:0] s2_chroma;
    logic [C_VIDEO_W-1:0] video;
    logic                 xsync_dly;

    logic [9:0]           ramp_sum;
    logic [C_RAMP_W-1:0]  ramp_y;
    logic [C_CPH_W-1:0]   hue;
    logic [C_CPH_W-1:0]   phase_n;
    logic signed [SW-1:0] luma_n;
    logic                 chroma_on;
    logic [2:0]           gain_n;
    logic signed [SW-1:0] sum_act;
    logic signed [SW-1:0] sum_burst;
    logic [C_VIDEO_W-1:0] video_n;

    always_comb begin
        ramp_sum  = {1'b0, bus.hctr[9:1]} + {1'b0, bus.vctr} + {2'b0, bus.fctr};
        ramp_y    = C_RAMP_W'(ramp_sum >> (8 - C_RAMP_W));
        hue       = C_CPH_W'(bus.hctr[8:6]);
        luma_n    = '0;
        chroma_on = 1'b0;
        case (mode_act)
            VSQ_MODE_RAMP: begin
                luma_n    = SW'({ramp_y, 1'b0});
                chroma_on = 1'b1;
            end
            VSQ_MODE_BARS: begin
                luma_n    = SW'(C_BAR_Y);
                chroma_on = 1'b1;
            end
            VSQ_MODE_FLAT: luma_n = SW'({1'b0, bus.level}) - PEDE_S;
            default: begin
                if (bus.hctr[5:0] == '0 || bus.vctr[4:0] == '0)
                    luma_n = SW'(MAX_CODE - C_PEDE);
            end
        endcase
        // Burst keeps its reference phase in every mode; only the picture chroma is mode-gated.
        phase_n = bus.burst ? bus.cph + C_CPH_W'(2 ** (C_CPH_W - 1)) : bus.cph + hue;
        gain_n  = (bus.burst || chroma_on) ? bus.gain : 3'd0;
    end

    always_comb begin
        sum_act   = PEDE_S + s2_luma + s2_chroma;
        sum_burst = PEDE_S + (s2_chroma >>> 1);
        if (!s2_xsync)
            video_n = '0;
        else if (s2_burst)
            video_n = C_VIDEO_W'(clamp_code(int'(sum_burst), MAX_CODE));
        else if (!s2_xblk)
            video_n = C_VIDEO_W'(C_PEDE);
        else
            video_n = C_VIDEO_W'(clamp_code(int'(sum_act), MAX_CODE));
    end

    // Reset fills the pipe with blank, non-sync samples so output sits at pedestal until refilled.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            mode_act  <= VSQ_MODE_RAMP;
            s1_xsync  <= 1'b1;
            s1_xblk   <= 1'b0;
            s1_burst  <= 1'b0;
            s1_luma   <= '0;
            s1_phase  <= '0;
            s1_gain   <= '0;
            s2_xsync  <= 1'b1;
            s2_xblk   <= 1'b0;
            s2_burst  <= 1'b0;
            s2_luma   <= '0;
            video     <= C_VIDEO_W'(C_PEDE);
            xsync_dly <= 1'b1;
        end else if (bus.ck_ee) begin
            if (bus.hctr == '0 && bus.vctr == '0)
                mode_act <= vsq_mode_e'(bus.mode);
            s1_xsync  <= bus.xsync;
            s1_xblk   <= bus.xblk;
            s1_burst  <= bus.burst;
            s1_luma   <= luma_n;
            s1_phase  <= phase_n;
            s1_gain   <= gain_n;
            s2_xsync  <= s1_xsync;
            s2_xblk   <= s1_xblk;
            s2_burst  <= s1_burst;
            s2_luma   <= s1_luma;
            video     <= video_n;
            xsync_dly <= s2_xsync;
        end
    end

    video_pattern_gen_chroma_lut #(
        .C_CPH_W (C_CPH_W),
        .OUT_W   (SW)
    ) u_chroma_lut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .en      (bus.ck_ee),
        .phase   (s1_phase),
        .gain    (s1_gain),
        .chroma  (s2_chroma)
    );

    assign bus.video     = video;
    assign bus.mode_act  = mode_act;
    assign bus.xsync_dly = xsync_dly;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen (5-bit DAC, pedestal 12, 8 phases);
// expected codes are worked out by hand from the pattern rules.
module tb_video_pattern_gen;
    logic clk_sys = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    video_pattern_gen_if #(.C_VIDEO_W(5), .C_CPH_W(3)) bus ();

    video_pattern_gen #(
        .C_VIDEO_W (5),
        .C_PEDE    (12),
        .C_CPH_W   (3),
        .C_BAR_Y   (8),
        .C_RAMP_W  (3)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic drive(input int h, input int v, input int cph);
        bus.hctr = 10'(h);
        bus.vctr = 9'(v);
        bus.cph  = 3'(cph);
    endtask

    task automatic expect3(input string tag, input int exp);
        step(3);
        check(tag, int'(bus.video), exp);
    endtask

    task automatic set_mode(input int m);
        bus.mode = 2'(m);
        drive(0, 0, 0);
        step(1);
        check("mode_latch", int'(bus.mode_act), m);
    endtask

    initial begin
        rst       = 1'b1;
        bus.ck_ee = 1'b1;
        bus.fctr  = 8'd0;
        bus.xblk  = 1'b1;
        bus.xsync = 1'b1;
        bus.burst = 1'b0;
        bus.mode  = 2'd0;
        bus.level = 5'd0;
        bus.gain  = 3'd4;
        drive(100, 50, 0);
        step(2);
        check("rst_video", int'(bus.video), 12);
        check("rst_mode", int'(bus.mode_act), 0);
        check("rst_xsync", int'(bus.xsync_dly), 1);

        rst = 1'b0;
        step(1);
        check("refill_pede", int'(bus.video), 12);
        step(2);
        check("ramp_basic", int'(bus.video), 24);

        // FLAT, including exact three-cycle latency
        set_mode(2);
        drive(100, 50, 0);
        bus.level = 5'd8;
        bus.gain  = 3'd0;
        expect3("flat_8", 8);
        bus.level = 5'd20;
        step(2);
        check("flat_latency", int'(bus.video), 8);
        step(1);
        check("flat_20", int'(bus.video), 20);
        bus.level = 5'd0;
        bus.gain  = 3'd4;
        bus.cph   = 3'd1;
        expect3("flat_low_clamp", 0);
        bus.level = 5'd31;
        expect3("flat_max", 31);

        set_mode(3);
        drive(64, 7, 0);
        expect3("grid_vline", 31);
        drive(65, 7, 0);
        expect3("grid_off", 12);
        drive(65, 32, 0);
        expect3("grid_hline", 31);

        // RAMP clamping and chroma scaling
        set_mode(0);
        bus.gain = 3'd4;
        drive(448, 1, 2);
        expect3("ramp_clamp_hi", 31);
        drive(448, 32, 6);
        expect3("ramp_neg_chroma", 6);
        bus.gain = 3'd1;
        drive(448, 32, 5);
        expect3("ramp_floor_shift", 11);
        bus.gain = 3'd0;
        drive(448, 1, 2);
        expect3("ramp_mono", 26);
        bus.fctr = 8'd40;
        expect3("ramp_frame_ofs", 12);
        bus.fctr = 8'd255;
        expect3("ramp_fctr_wrap", 26);
        bus.fctr = 8'd0;

        // BARS, sync tip, burst and blanking
        set_mode(1);
        bus.gain = 3'd4;
        drive(192, 50, 0);
        expect3("bars_3", 23);
        bus.xsync = 1'b0;
        step(2);
        check("sync_lat_video", int'(bus.video), 23);
        check("sync_lat_flag", int'(bus.xsync_dly), 1);
        step(1);
        check("sync_tip_video", int'(bus.video), 0);
        check("sync_tip_flag", int'(bus.xsync_dly), 0);
        bus.xsync = 1'b1;
        bus.xblk  = 1'b0;
        bus.burst = 1'b1;
        expect3("burst_ph0", 10);
        bus.burst = 1'b0;
        expect3("blank_pede", 12);
        bus.xblk = 1'b1;
        drive(320, 50, 0);
        expect3("bars_5", 14);

        // mode request only honoured at the first pixel of a frame
        set_mode(0);
        bus.mode = 2'd2;
        drive(10, 100, 0);
        step(1);
        check("mode_hold_mid", int'(bus.mode_act), 0);
        drive(0, 100, 0);
        step(1);
        check("mode_hold_h0", int'(bus.mode_act), 0);
        drive(5, 0, 0);
        step(1);
        check("mode_hold_v0", int'(bus.mode_act), 0);
        bus.ck_ee = 1'b0;
        drive(0, 0, 0);
        step(1);
        check("mode_hold_stall", int'(bus.mode_act), 0);
        bus.ck_ee = 1'b1;
        step(1);
        check("mode_switch", int'(bus.mode_act), 2);

        // clock-enable freeze mid-line
        drive(100, 50, 0);
        bus.level = 5'd13;
        step(1);
        bus.level = 5'd14;
        step(1);
        bus.level = 5'd15;
        step(1);
        check("freeze_pre", int'(bus.video), 13);
        bus.ck_ee = 1'b0;
        bus.level = 5'd31;
        bus.mode  = 2'd3;
        drive(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("freeze_hold", int'(bus.video), 13);
        end
        check("freeze_mode", int'(bus.mode_act), 2);
        bus.ck_ee = 1'b1;
        bus.mode  = 2'd2;
        drive(100, 50, 0);
        for (int i = 0; i < 3; i++) begin
            bus.level = 5'(16 + i);
            step(1);
            check("resume_seq", int'(bus.video), 14 + i);
        end

        // reset pulse mid-line, enable low
        rst       = 1'b1;
        bus.ck_ee = 1'b0;
        step(1);
        check("mid_rst_video", int'(bus.video), 12);
        check("mid_rst_mode", int'(bus.mode_act), 0);
        check("mid_rst_xsync", int'(bus.xsync_dly), 1);
        rst       = 1'b0;
        bus.ck_ee = 1'b1;
        bus.gain  = 3'd4;
        drive(448, 1, 2);
        step(1);
        check("post_rst_1", int'(bus.video), 12);
        step(1);
        check("post_rst_2", int'(bus.video), 12);
        step(1);
        check("post_rst_3", int'(bus.video), 31);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
